// File: rtl/rhd_spi_responder.sv
// rhd_spi_responder
//   Chip-side RHD2164-style SPI responder. Samples SCLK/CS/MOSI in the clk
//   domain, decodes 16-bit commands and returns each result on MISO two
//   frames later through a two-stage result pipeline.
//   Optional build macro: RHD_SAMPLE_COUNTER_EN adds a 16-bit sample counter
//   that is added to every CONVERT result.

module rhd_spi_responder #(
    parameter logic [15:0] STARTING_SEED = 16'd0,
    parameter logic [7:0]  CHIP_ID       = 8'd4,
    parameter logic [7:0]  NUM_AMPS      = 8'h40,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        frame_done,
    output logic        frame_error,
    output logic [15:0] cmd_out
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic        sclk_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sclk_prev;
    logic        cs_prev;
    logic        in_frame;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_fall;
    logic        cs_rise;
    logic        accept;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;
    logic [15:0] res_q1;
    logic [15:0] res_q2;
    logic [15:0] dec_result;
    logic [15:0] conv_offset;
    logic [5:0]  addr_field;
    logic [7:0]  rd_val;
    logic [7:0]  regs [0:17];

    // Bring the SPI pins into the clk domain and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // SCLK edges count only while CS was low on both samples, so an edge that
    // coincides with the CS fall is dropped and the CS fall wins.
    assign in_frame  = ~cs_s & ~cs_prev;
    assign sclk_rise = in_frame & sclk_s & ~sclk_prev;
    assign sclk_fall = in_frame & ~sclk_s & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign accept    = cs_rise & (bit_cnt == 5'd16);
    assign addr_field = rx_shift[13:8];

    // Shift command bits in on SCLK rise and result bits out on SCLK fall
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
            MISO     <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt  <= '0;
            tx_shift <= res_q2;
            MISO     <= res_q2[15];
        end else begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[14:0], mosi_s};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (sclk_fall) begin
                tx_shift <= {tx_shift[14:0], 1'b0};
                MISO     <= tx_shift[14];
            end
        end
    end

    // On CS rise accept a full frame (advance pipeline) or flag a short/long one
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_out     <= '0;
            res_q1      <= '0;
            res_q2      <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done  <= accept;
            frame_error <= cs_rise & ~accept;
            if (accept) begin
                cmd_out <= rx_shift;
                res_q2  <= res_q1;
                res_q1  <= dec_result;
            end
        end
    end

    // Commit WRITE commands to the RW registers when the frame is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 18; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (accept && rx_shift[15:14] == 2'b10 && addr_field <= 6'd17) begin
            regs[addr_field[4:0]] <= rx_shift[7:0];
        end
    end

`ifdef RHD_SAMPLE_COUNTER_EN
    logic [15:0] sample_cnt;

    // Count accepted CONVERTs of channel 0; CLEAR restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (accept && rx_shift == 16'h6A00) begin
            sample_cnt <= '0;
        end else if (accept && rx_shift[15:8] == 8'h00) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

    assign conv_offset = sample_cnt;
`else
    assign conv_offset = 16'd0;
`endif

    // Register map seen by READ
    always_comb begin
        rd_val = 8'h00;
        if (addr_field <= 6'd17) begin
            rd_val = regs[addr_field[4:0]];
        end else begin
            case (addr_field)
                6'd40:   rd_val = 8'h49;  // I
                6'd41:   rd_val = 8'h4E;  // N
                6'd42:   rd_val = 8'h54;  // T
                6'd43:   rd_val = 8'h41;  // A
                6'd44:   rd_val = 8'h4E;  // N
                6'd60:   rd_val = 8'h01;
                6'd61:   rd_val = 8'h00;
                6'd62:   rd_val = NUM_AMPS;
                6'd63:   rd_val = CHIP_ID;
                default: rd_val = 8'h00;
            endcase
        end
    end

    // Result of the command currently held in rx_shift
    always_comb begin
        dec_result = 16'h0000;
        case (rx_shift[15:14])
            2'b00:   dec_result = STARTING_SEED + {10'd0, addr_field} + conv_offset;
            2'b01:   dec_result = 16'h0000;  // CALIBRATE, CLEAR and unknown
            2'b10:   dec_result = {8'hFF, rx_shift[7:0]};
            default: dec_result = {8'h00, rd_val};
        endcase
    end

endmodule

// File: tb/tb_rhd_spi_responder.sv
// tb_rhd_spi_responder: bench for rhd_spi_responder (STARTING_SEED = 144).
// Honours RHD_SAMPLE_COUNTER_EN when the design is built with it.

module tb_rhd_spi_responder;

    localparam logic [15:0] SEED = 16'd144;
    localparam logic [7:0]  CHIP = 8'd4;
    localparam logic [7:0]  AMPS = 8'h40;
`ifdef RHD_SAMPLE_COUNTER_EN
    localparam logic [15:0] CNT1 = 16'd1;
`else
    localparam logic [15:0] CNT1 = 16'd0;
`endif

    logic        clk;
    logic        rst;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] cmd_out;

    int checks;
    int failures;

    // reference model state
    logic [15:0] exp_q[$];
    logic [7:0]  model_regs [0:17];
    logic [15:0] model_cnt;
    logic [15:0] last_cmd;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs [17];

    rhd_spi_responder #(
        .STARTING_SEED(SEED),
        .CHIP_ID(CHIP),
        .NUM_AMPS(AMPS),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SCLK(SCLK),
        .CS(CS),
        .MOSI(MOSI),
        .MISO(MISO),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .cmd_out(cmd_out)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 18; i++) model_regs[i] = 8'h00;
        model_cnt = 16'h0000;
        last_cmd  = 16'h0000;
    endtask

    function automatic logic [7:0] ref_read(input logic [5:0] a);
        logic [7:0] intan [5];
        intan = '{8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E};
        if (a <= 6'd17) return model_regs[a[4:0]];
        if (a >= 6'd40 && a <= 6'd44) return intan[a - 6'd40];
        if (a == 6'd60) return 8'h01;
        if (a == 6'd62) return AMPS;
        if (a == 6'd63) return CHIP;
        return 8'h00;
    endfunction

    task automatic ref_accept(input logic [15:0] cmd);
        logic [15:0] res;
        logic [5:0]  a;
        a = cmd[13:8];
        case (cmd[15:14])
            2'b00: begin
                res = SEED + {10'd0, a} + model_cnt;
`ifdef RHD_SAMPLE_COUNTER_EN
                if (a == 6'd0) model_cnt = model_cnt + 16'd1;
`endif
            end
            2'b01: begin
                res = 16'h0000;
`ifdef RHD_SAMPLE_COUNTER_EN
                if (cmd == 16'h6A00) model_cnt = 16'h0000;
`endif
            end
            2'b10: begin
                res = {8'hFF, cmd[7:0]};
                if (a <= 6'd17) model_regs[a[4:0]] = cmd[7:0];
            end
            default: res = {8'h00, ref_read(a)};
        endcase
        void'(exp_q.pop_front());
        exp_q.push_back(res);
        last_cmd = cmd;
    endtask

    // ---------------- driver ----------------
    task automatic run_frame(input logic [15:0] cmd, input int nbits,
                             output logic [15:0] rx, output int n_done, output int n_err);
        rx = 16'h0000;
        n_done = 0;
        n_err = 0;
        CS = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            tick(5);
            if (i < 16) rx = {rx[14:0], MISO};
            SCLK = 1'b1;
            tick(5);
            SCLK = 1'b0;
        end
        tick(5);
        CS = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (frame_done) n_done++;
            if (frame_error) n_err++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic model_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rx);
        logic [15:0] head;
        int k;
        int nd;
        int ne;
        head = exp_q[0];
        run_frame(cmd, nbits, rx, nd, ne);
        k = (nbits < 16) ? nbits : 16;
        check("miso_word", rx, head >> (16 - k));
        if (nbits == 16) begin
            check("frame_done_cnt", 16'(nd), 16'd1);
            check("frame_error_cnt", 16'(ne), 16'd0);
            check("cmd_out", cmd_out, cmd);
            ref_accept(cmd);
        end else begin
            check("frame_error_cnt", 16'(ne), 16'd1);
            check("frame_done_cnt", 16'(nd), 16'd0);
            check("cmd_out_held", cmd_out, last_cmd);
        end
    endtask

    function automatic logic [5:0] addr_pick();
        if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 22));
        return 6'($urandom_range(38, 63));
    endfunction

    // watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] rx;
        logic [15:0] words [10];
        logic [15:0] cmd;
        logic [15:0] t6_exp [7];
        int nb;
        int sel;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        SCLK = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        model_reset();

        vecs[0]  = '{16'h0000, 16'h0000};
        vecs[1]  = '{16'h0100, 16'h0000};
        vecs[2]  = '{16'h0200, 16'h0090};
        vecs[3]  = '{16'h85A7, 16'h0091 + CNT1};
        vecs[4]  = '{16'hC500, 16'h0092 + CNT1};
        vecs[5]  = '{16'hFF00, 16'hFFA7};
        vecs[6]  = '{16'h2000, 16'h00A7};
        vecs[7]  = '{16'h2100, 16'h0004};
        vecs[8]  = '{16'hE800, 16'h00B0 + CNT1};
        vecs[9]  = '{16'hE900, 16'h00B1 + CNT1};
        vecs[10] = '{16'hEA00, 16'h0049};
        vecs[11] = '{16'hEB00, 16'h004E};
        vecs[12] = '{16'hEC00, 16'h0054};
        vecs[13] = '{16'h5500, 16'h0041};
        vecs[14] = '{16'h6A00, 16'h004E};
        vecs[15] = '{16'hFE00, 16'h0000};
        vecs[16] = '{16'hFF00, 16'h0000};

`ifdef RHD_SAMPLE_COUNTER_EN
        t6_exp = '{16'd144, 16'd145, 16'd146, 16'd0, 16'd144, 16'd145, 16'd146};
`else
        t6_exp = '{16'd144, 16'd144, 16'd144, 16'd0, 16'd144, 16'd144, 16'd144};
`endif

        // reset state
        tick(4);
        check("rst_miso", {15'd0, MISO}, 16'd0);
        check("rst_frame_done", {15'd0, frame_done}, 16'd0);
        check("rst_frame_error", {15'd0, frame_error}, 16'd0);
        check("rst_cmd_out", cmd_out, 16'd0);
        rst = 1'b0;
        tick(4);

        // table: convert / write / read / ID / INTAN
        for (int i = 0; i < 17; i++) begin
            model_frame(vecs[i].cmd, 16, rx);
            check("table_miso", rx, vecs[i].exp_miso);
        end

        // short frame: error, no pipeline advance
        model_frame(16'h0300, 12, rx);
        check("err_partial_word", rx, 16'h0004);
        model_frame(16'hFC00, 16, rx);
        check("after_err_word0", rx, 16'h0040);
        model_frame(16'hFD00, 16, rx);
        check("after_err_word1", rx, 16'h0004);

        // sample counter sequence
        model_frame(16'h6A00, 16, words[0]);
        for (int i = 1; i < 10; i++) begin
            if (i == 4) cmd = 16'h6A00;
            else if (i >= 8) cmd = 16'h5500;
            else cmd = 16'h0000;
            model_frame(cmd, 16, words[i]);
        end
        for (int i = 0; i < 7; i++) begin
            check("counter_seq", words[i + 3], t6_exp[i]);
        end

        // reset mid-frame with CS held low
        model_frame(16'h85A7, 16, rx);
        model_frame(16'hFF00, 16, rx);
        CS = 1'b0;
        tick(6);
        for (int i = 0; i < 7; i++) begin
            MOSI = 1'b1;
            tick(5);
            SCLK = 1'b1;
            tick(5);
            SCLK = 1'b0;
        end
        tick(2);
        rst = 1'b1;
        tick(2);
        check("midrst_miso", {15'd0, MISO}, 16'd0);
        check("midrst_cmd_out", cmd_out, 16'd0);
        rst = 1'b0;
        tick(8);
        check("postrst_miso", {15'd0, MISO}, 16'd0);
        CS = 1'b1;
        tick(12);
        model_reset();
        model_frame(16'hC500, 16, rx);
        check("postrst_word0", rx, 16'h0000);
        model_frame(16'h0000, 16, rx);
        model_frame(16'h0000, 16, rx);
        check("postrst_reg5_cleared", rx, 16'h0000);

        // randomized frames against the model
        for (int n = 0; n < 120; n++) begin
            sel = int'($urandom_range(0, 6));
            nb = 16;
            case (sel)
                0: cmd = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
                1: cmd = {2'b10, addr_pick(), 8'($urandom)};
                2: cmd = {2'b11, addr_pick(), 8'($urandom)};
                3: cmd = ($urandom_range(0, 1) == 1) ? 16'h5500 : 16'h6A00;
                4: cmd = {2'b01, 14'($urandom)};
                5: begin
                    cmd = 16'($urandom);
                    nb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15))
                                                     : int'($urandom_range(17, 20));
                end
                default: cmd = {8'h00, 8'($urandom)};
            endcase
            model_frame(cmd, nb, rx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
